// File: rtl/e_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states, decode helpers.
// The madd/msub codes only decode as real ops in e_mdu when MDU_MADD_EN is defined.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOPE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MSUB  = 4'd8
  } mduop_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Counter must hold N-1 for the longer latency; never narrower than one bit.
  function automatic int cnt_width(input int multCycles, input int divCycles);
    int m;
    m = (multCycles > divCycles) ? multCycles : divCycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  function automatic logic is_div(input mduop_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_long(input mduop_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Combinational 2*WIDTH result generator for mult/div and the multiply-accumulate forms.
// wr drops on divide by zero so HI/LO keep their value; madd/msub only reach here with MDU_MADD_EN.
module e_mdu_core
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mduop_e             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] res,
  output logic               wr
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] prodS, prodU, acc;
  logic [WIDTH-1:0]   dA, dB, q, r, qOut, rOut;
  logic               sgn;

  // Sign-extending to 2*WIDTH makes the modular product equal the signed product.
  assign prodS = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prodU = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign acc   = {hi, lo};

  // Signed divide runs on magnitudes; MIN/-1 falls out as lo=MIN, hi=0 naturally.
  assign sgn  = (op == OP_DIV);
  assign dA   = (sgn && a[WIDTH-1]) ? (~a) + ONE : a;
  assign dB   = (b == '0) ? ONE : ((sgn && b[WIDTH-1]) ? (~b) + ONE : b);
  assign q    = dA / dB;
  assign r    = dA % dB;
  assign qOut = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? (~q) + ONE : q;
  assign rOut = (sgn && a[WIDTH-1]) ? (~r) + ONE : r;

  always_comb begin
    res = '0;
    wr  = 1'b0;
    case (op)
      OP_MULT:  begin res = prodS;       wr = 1'b1; end
      OP_MULTU: begin res = prodU;       wr = 1'b1; end
      OP_DIV,
      OP_DIVU:  begin res = {rOut, qOut}; wr = (b != '0); end
      OP_MADD:  begin res = acc + prodS; wr = 1'b1; end
      OP_MSUB:  begin res = acc - prodS; wr = 1'b1; end
      default:  begin res = '0;          wr = 1'b0; end
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// EX-stage multiply/divide unit: IDLE/RUN latency counter plus the HI/LO registers.
// Define MDU_MADD_EN to decode the madd/msub accumulate ops; otherwise they act as nope.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mduOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  state_e             state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  mduop_e             opDec, opQ;
  logic [WIDTH-1:0]   aQ, bQ, hiNext, loNext;
  logic [2*WIDTH-1:0] coreRes;
  logic               coreWr, latch;

  // Unknown codes, and madd/msub in the default build, collapse to nope.
  always_comb begin
    opDec = OP_NOPE;
    case (mduOp)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: opDec = mduop_e'(mduOp);
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB: opDec = mduop_e'(mduOp);
`endif
      default: opDec = OP_NOPE;
    endcase
  end

  e_mdu_core #(.WIDTH(WIDTH)) u_core (
    .op  (opQ),
    .a   (aQ),
    .b   (bQ),
    .hi  (hi),
    .lo  (lo),
    .res (coreRes),
    .wr  (coreWr)
  );

  // The result is evaluated from the latched operands at completion, so
  // the accumulate forms see HI/LO as they are when the op retires.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    hiNext    = hi;
    loNext    = lo;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_long(opDec)) begin
            stateNext = RUN;
            cntNext   = is_div(opDec) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            latch     = 1'b1;
          end else if (opDec == OP_MTHI) begin
            hiNext = srcA;
          end else if (opDec == OP_MTLO) begin
            loNext = srcA;
          end
        end
      end
      RUN: begin
        if (cnt == '0) begin
          stateNext = IDLE;
          if (coreWr) {hiNext, loNext} = coreRes;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opQ   <= OP_NOPE;
      aQ    <= '0;
      bQ    <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      hi    <= hiNext;
      lo    <= loNext;
      if (latch) begin
        opQ <= opDec;
        aQ  <= srcA;
        bQ  <= srcB;
      end
    end
  end

  assign busy  = (state == RUN);
  assign stall = busy | (start & is_long(opDec));

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu at default parameters (WIDTH=32, 5/10 cycle latency).
// The accumulate section is exercised when MDU_MADD_EN is defined, otherwise its decode-as-nope.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mduOp;
  logic [31:0] srcA, srcB;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int compared   = 0;
  int mismatched = 0;
  int n;
  logic s;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mduOp (mduOp),
    .srcA  (srcA),
    .srcB  (srcB),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one op for a single edge and report the combinational stall seen before it.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic stallSeen);
    start = 1'b1;
    mduOp = op;
    srcA  = a;
    srcB  = b;
    #1;
    stallSeen = stall;
    step();
    start = 1'b0;
    mduOp = OP_NOPE;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mduOp = OP_NOPE;
    srcA  = '0;
    srcB  = '0;
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    checkOutput("reset_busy", busy, 0);

    // Reset during cycle 2 of a MULT clears everything at once and nothing lands later.
    applyStimulus(OP_MTHI, 32'hAA, 0, s);
    applyStimulus(OP_MTLO, 32'hBB, 0, s);
    checkOutput("preload_hi", hi, 32'hAA);
    checkOutput("preload_lo", lo, 32'hBB);
    applyStimulus(OP_MULT, 3, 4, s);
    step();
    checkOutput("midop_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midop_rst_busy", busy, 0);
    checkOutput("midop_rst_hi", hi, 0);
    checkOutput("midop_rst_lo", lo, 0);
    step();
    reset = 1'b0;
    repeat (8) step();
    checkOutput("post_rst_hi", hi, 0);
    checkOutput("post_rst_lo", lo, 0);
    checkOutput("post_rst_busy", busy, 0);

    applyStimulus(OP_MULT, 32'hFFFFFFFF, 2, s);
    checkOutput("mult_stall", s, 1);
    checkOutput("mult_hold_hi", hi, 0);
    checkOutput("mult_hold_lo", lo, 0);
    waitIdle(n);
    checkOutput("mult_cycles", n, 5);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFFE);

    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 2, s);
    waitIdle(n);
    checkOutput("multu_cycles", n, 5);
    checkOutput("multu_hi", hi, 1);
    checkOutput("multu_lo", lo, 32'hFFFFFFFE);

    applyStimulus(OP_DIV, 32'hFFFFFFF9, 2, s);
    checkOutput("div_stall", s, 1);
    waitIdle(n);
    checkOutput("div_cycles", n, 10);
    checkOutput("div_lo", lo, 32'hFFFFFFFD);
    checkOutput("div_hi", hi, 32'hFFFFFFFF);

    applyStimulus(OP_DIVU, 7, 0, s);
    waitIdle(n);
    checkOutput("divz_cycles", n, 10);
    checkOutput("divz_hi", hi, 32'hFFFFFFFF);
    checkOutput("divz_lo", lo, 32'hFFFFFFFD);

    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, s);
    waitIdle(n);
    checkOutput("ovf_lo", lo, 32'h80000000);
    checkOutput("ovf_hi", hi, 0);

    applyStimulus(OP_MTHI, 32'h1234, 0, s);
    checkOutput("mthi_stall", s, 0);
    checkOutput("mthi_busy", busy, 0);
    checkOutput("mthi_hi", hi, 32'h1234);
    checkOutput("mthi_lo", lo, 32'h80000000);

    // Ops presented while busy are dropped; the first op alone decides HI/LO.
    applyStimulus(OP_MULT, 6, 7, s);
    applyStimulus(OP_MULT, 100, 100, s);
    checkOutput("busy_mult_stall", s, 1);
    applyStimulus(OP_MTLO, 32'hDEAD, 0, s);
    checkOutput("busy_mtlo_stall", s, 1);
    checkOutput("busy_mtlo_lo_hold", lo, 32'h80000000);
    waitIdle(n);
    checkOutput("busy_rest_cycles", n, 3);
    checkOutput("busy_hi", hi, 0);
    checkOutput("busy_lo", lo, 42);

    applyStimulus(4'hF, 32'h5555, 0, s);
    checkOutput("unknown_stall", s, 0);
    checkOutput("unknown_busy", busy, 0);
    checkOutput("unknown_lo", lo, 42);

`ifdef MDU_MADD_EN
    applyStimulus(OP_MTHI, 0, 0, s);
    applyStimulus(OP_MTLO, 5, 0, s);
    applyStimulus(OP_MADD, 3, 4, s);
    checkOutput("madd_stall", s, 1);
    waitIdle(n);
    checkOutput("madd_cycles", n, 5);
    checkOutput("madd_hi", hi, 0);
    checkOutput("madd_lo", lo, 17);
    applyStimulus(OP_MSUB, 1, 20, s);
    checkOutput("msub_stall", s, 1);
    waitIdle(n);
    checkOutput("msub_cycles", n, 5);
    checkOutput("msub_hi", hi, 32'hFFFFFFFF);
    checkOutput("msub_lo", lo, 32'hFFFFFFFD);
`else
    applyStimulus(OP_MADD, 3, 4, s);
    checkOutput("madd_nope_stall", s, 0);
    checkOutput("madd_nope_busy", busy, 0);
    checkOutput("madd_nope_lo", lo, 42);
    applyStimulus(OP_MSUB, 1, 20, s);
    checkOutput("msub_nope_stall", s, 0);
    checkOutput("msub_nope_hi", hi, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
